ms_beat_sequencer: RTL and testbench

- Initiator and timing source for the main store (MS) and accumulator (A). Generates scan/action beats, output and input phases, and MS address, zero and write data.
- Holds the control instruction counter (CI) and present instruction (PI). Drives the function bits to A.
- Sits between the run/halt controls and the MS/A pair. Each instruction is one fetch beat pair followed by one execute beat pair.

---
 rtl/ms_pkg.sv | 35 +++
 rtl/ms_ci_counter.sv | 26 ++
 rtl/ms_beat_sequencer.sv | 125 ++++++++++++
 tb/tb_ms_beat_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_pkg.sv
// ms_pkg: shared widths, opcodes, field offsets and beat-state encoding
// for the main-store beat sequencer. STEP_MODE_EN adds the PAUSE state.
package ms_pkg;

    localparam int MS_LINE_LENGTH = 40;
    localparam int MS_ADDR_BITS   = 10;
    localparam int MS_FUNC_BITS   = 6;

    // Instruction word layout: operand in [0:9], opcode in [10:15]
    localparam int MS_OPERAND_POS = 0;
    localparam int MS_OPCODE_POS  = MS_ADDR_BITS;

    localparam logic [0:MS_FUNC_BITS-1] INST_CMP = 6'b000101;
    localparam logic [0:MS_FUNC_BITS-1] INST_JMP = 6'b001101;
    localparam logic [0:MS_FUNC_BITS-1] INST_STA = 6'b010100;
    localparam logic [0:MS_FUNC_BITS-1] INST_LDA = 6'b100000;
    localparam logic [0:MS_FUNC_BITS-1] INST_HLT = 6'b111111;

    typedef enum logic [3:0] {
        IDLE,
        F_SCAN_OUT,
        F_SCAN_IN,
        F_ACT_OUT,
        F_ACT_IN,
        E_SCAN_OUT,
        E_SCAN_IN,
        E_ACT_OUT,
        E_ACT_IN,
`ifdef STEP_MODE_EN
        PAUSE,
`endif
        HALT
    } state_t;

endpackage

// File: rtl/ms_ci_counter.sv
// ms_ci_counter: control instruction counter with increment/skip, load and natural wrap.
// Ports: w_CLK clock, w_RST_N async active-low reset, w_INC step CI by one,
//        w_LOAD load b_LOAD_VAL (wins over w_INC), b_CI current count.
module ms_ci_counter
    import ms_pkg::*;
#(
    parameter int W = MS_ADDR_BITS
) (
    input  logic         w_CLK,
    input  logic         w_RST_N,
    input  logic         w_INC,
    input  logic         w_LOAD,
    input  logic [0:W-1] b_LOAD_VAL,
    output logic [0:W-1] b_CI
);

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N)
            b_CI <= '0;
        else if (w_LOAD)
            b_CI <= b_LOAD_VAL;
        else if (w_INC)
            b_CI <= b_CI + W'(1);
    end

endmodule

// File: rtl/ms_beat_sequencer.sv
// ms_beat_sequencer: beat/phase generator and instruction sequencer for the MS/A pair.
// Ports: w_CLK clock, w_RST_N async active-low reset, w_RUN run level, w_A_NEG A sign,
//        b_MS_DATA_OUT registered MS read data, b_A_DATA_OUT A value for STA,
//        ready_out/ready_in output/input phase, w_HS scan beat, w_ACTION action beat,
//        b_MS_ADDR/b_MS_ZERO/b_MS_DATA_IN MS address, erase mask and write data,
//        b_FST_OUT function bits to A, w_A_ZERO clear A read path, b_CI current CI,
//        w_HALTED halt indicator.
// Optional: STEP_MODE_EN adds w_STEP and a PAUSE state between instructions.
module ms_beat_sequencer
    import ms_pkg::*;
#(
    parameter int LINE_LENGTH         = MS_LINE_LENGTH,
    parameter int INSTR_ADDR_BITS     = MS_ADDR_BITS,
    parameter int INSTR_FUNCTION_BITS = MS_FUNC_BITS
) (
    input  logic                           w_CLK,
    input  logic                           w_RST_N,
    input  logic                           w_RUN,
    input  logic                           w_A_NEG,
`ifdef STEP_MODE_EN
    input  logic                           w_STEP,
`endif
    input  logic [0:LINE_LENGTH-1]         b_MS_DATA_OUT,
    input  logic [0:LINE_LENGTH-1]         b_A_DATA_OUT,
    output logic                           ready_out,
    output logic                           ready_in,
    output logic                           w_HS,
    output logic                           w_ACTION,
    output logic [0:INSTR_ADDR_BITS-1]     b_MS_ADDR,
    output logic [0:LINE_LENGTH-1]         b_MS_ZERO,
    output logic [0:LINE_LENGTH-1]         b_MS_DATA_IN,
    output logic [0:INSTR_FUNCTION_BITS-1] b_FST_OUT,
    output logic                           w_A_ZERO,
    output logic [0:INSTR_ADDR_BITS-1]     b_CI,
    output logic                           w_HALTED
);

    state_t                         state_q, state_d;
    logic [0:LINE_LENGTH-1]         pi;
    logic [0:INSTR_ADDR_BITS-1]     operand;
    logic [0:INSTR_FUNCTION_BITS-1] opcode;
    logic                           e_act, sta_wr, ci_inc, ci_load, unused;

    assign operand = pi[MS_OPERAND_POS +: INSTR_ADDR_BITS];
    assign opcode  = pi[MS_OPCODE_POS +: INSTR_FUNCTION_BITS];
    assign unused  = &{1'b0, pi[MS_OPCODE_POS+INSTR_FUNCTION_BITS:LINE_LENGTH-1]};

`ifdef STEP_MODE_EN
    logic step_q, step_go;
    localparam state_t RESUME = PAUSE;

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N)
            step_q <= 1'b0;
        else
            step_q <= w_STEP;
    end

    assign step_go = w_STEP & ~step_q;
`else
    localparam state_t RESUME = F_SCAN_OUT;
`endif

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            state_q <= IDLE;
            pi      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == F_ACT_IN)
                pi <= b_MS_DATA_OUT;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = w_RUN ? F_SCAN_OUT : IDLE;
            F_SCAN_OUT: state_d = F_SCAN_IN;
            F_SCAN_IN:  state_d = F_ACT_OUT;
            F_ACT_OUT:  state_d = F_ACT_IN;
            F_ACT_IN:   state_d = E_SCAN_OUT;
            E_SCAN_OUT: state_d = E_SCAN_IN;
            E_SCAN_IN:  state_d = E_ACT_OUT;
            E_ACT_OUT:  state_d = E_ACT_IN;
            E_ACT_IN:   state_d = (opcode == INST_HLT) ? HALT : !w_RUN ? IDLE : RESUME;
            HALT:       state_d = w_RUN ? HALT : IDLE;
`ifdef STEP_MODE_EN
            PAUSE:      state_d = !w_RUN ? IDLE : step_go ? F_SCAN_OUT : PAUSE;
`endif
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out    = state_q inside {F_SCAN_OUT, F_ACT_OUT, E_SCAN_OUT, E_ACT_OUT};
        ready_in     = state_q inside {F_SCAN_IN, F_ACT_IN, E_SCAN_IN, E_ACT_IN};
        w_HS         = state_q inside {F_SCAN_OUT, F_SCAN_IN, E_SCAN_OUT, E_SCAN_IN};
        w_ACTION     = state_q inside {F_ACT_OUT, F_ACT_IN, E_ACT_OUT, E_ACT_IN};
        w_HALTED     = state_q == HALT;
        e_act        = state_q inside {E_ACT_OUT, E_ACT_IN};
        sta_wr       = state_q == E_ACT_IN && opcode == INST_STA;
        b_MS_ADDR    = e_act ? operand : b_CI;
        // JMP outside execute action keeps A from latching on fetch/scan beats
        b_FST_OUT    = e_act ? opcode : INST_JMP;
        w_A_ZERO     = e_act && opcode == INST_LDA;
        b_MS_ZERO    = sta_wr ? '1 : '0;
        b_MS_DATA_IN = sta_wr ? b_A_DATA_OUT : '0;
        // fetch advances CI; CMP with A negative skips one more word
        ci_inc       = state_q == F_ACT_IN || (state_q == E_ACT_IN && opcode == INST_CMP && w_A_NEG);
        ci_load      = state_q == E_ACT_IN && opcode == INST_JMP;
    end

    ms_ci_counter #(
        .W(INSTR_ADDR_BITS)
    ) u_ci (
        .w_CLK      (w_CLK),
        .w_RST_N    (w_RST_N),
        .w_INC      (ci_inc),
        .w_LOAD     (ci_load),
        .b_LOAD_VAL (b_MS_DATA_OUT[0 +: INSTR_ADDR_BITS]),
        .b_CI       (b_CI)
    );

endmodule

// File: tb/tb_ms_beat_sequencer.sv
// tb_ms_beat_sequencer: table-driven and scoreboard checks of ms_beat_sequencer with a small MS model.
module tb_ms_beat_sequencer;

    localparam logic [5:0] OP_NOP = 6'b000011;
    localparam logic [5:0] OP_UNK = 6'b011000;
    localparam logic [5:0] OP_CMP = 6'b000101;
    localparam logic [5:0] OP_JMP = 6'b001101;
    localparam logic [5:0] OP_STA = 6'b010100;
    localparam logic [5:0] OP_LDA = 6'b100000;
    localparam logic [5:0] OP_HLT = 6'b111111;

    logic        w_CLK = 1'b0;
    logic        w_RST_N = 1'b0;
    logic        w_RUN = 1'b0;
    logic        w_A_NEG = 1'b0;
`ifdef STEP_MODE_EN
    logic        w_STEP = 1'b0;
`endif
    logic [0:39] ms_out;
    logic [0:39] a_val = '0;
    logic        ready_out, ready_in, w_HS, w_ACTION, w_A_ZERO, w_HALTED;
    logic [0:9]  b_MS_ADDR, b_CI;
    logic [0:39] b_MS_ZERO, b_MS_DATA_IN;
    logic [0:5]  b_FST_OUT;

    logic [0:39] mem [1024];
    logic [0:39] nopw;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [4:0]  ph;
        logic [9:0]  addr;
        logic [9:0]  ci;
        logic [5:0]  fst;
        logic        az;
        logic [39:0] zero;
        logic [39:0] din;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       nm;
        logic [5:0]  op;
        logic [9:0]  opnd;
        logic [9:0]  start;
        logic        neg;
        logic [39:0] aval;
        logic [39:0] tgt;
        logic        az;
        logic [39:0] zero;
        logic [39:0] din;
        logic [9:0]  nxt;
    } vec_t;
    vec_t vt[6];

    logic [3:0] beat_ph[8];

    ms_beat_sequencer dut (
        .w_CLK        (w_CLK),
        .w_RST_N      (w_RST_N),
        .w_RUN        (w_RUN),
        .w_A_NEG      (w_A_NEG),
`ifdef STEP_MODE_EN
        .w_STEP       (w_STEP),
`endif
        .b_MS_DATA_OUT(ms_out),
        .b_A_DATA_OUT (a_val),
        .ready_out    (ready_out),
        .ready_in     (ready_in),
        .w_HS         (w_HS),
        .w_ACTION     (w_ACTION),
        .b_MS_ADDR    (b_MS_ADDR),
        .b_MS_ZERO    (b_MS_ZERO),
        .b_MS_DATA_IN (b_MS_DATA_IN),
        .b_FST_OUT    (b_FST_OUT),
        .w_A_ZERO     (w_A_ZERO),
        .b_CI         (b_CI),
        .w_HALTED     (w_HALTED)
    );

    always #5 w_CLK = ~w_CLK;

    // main store: registers read data at the end of each output phase
    always @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N)
            ms_out <= '0;
        else if (ready_out)
            ms_out <= mem[b_MS_ADDR];
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation bound reached, required $finish earlier");
        $fatal(1);
    end

    function automatic logic [0:39] mk(input logic [5:0] op, input logic [9:0] opnd);
        logic [0:39] w;
        w = '0;
        w[0:9]   = opnd;
        w[10:15] = op;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] phases();
        return {ready_out, ready_in, w_HS, w_ACTION, w_HALTED};
    endfunction

    task automatic push_instr(input logic [9:0] ci, input logic [5:0] op, input logic [9:0] opnd,
                              input logic az, input logic [39:0] z7, input logic [39:0] d7);
        exp_t       e;
        logic [9:0] c1;
        c1 = ci + 10'd1;
        for (int b = 0; b < 8; b++) begin
            e.ph   = {beat_ph[b], 1'b0};
            e.addr = b < 4 ? ci : b < 6 ? c1 : opnd;
            e.ci   = b < 4 ? ci : c1;
            e.fst  = b >= 6 ? op : OP_JMP;
            e.az   = b >= 6 && az;
            e.zero = b == 7 ? z7 : 40'h0;
            e.din  = b == 7 ? d7 : 40'h0;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag, input int n);
        exp_t e;
        repeat (n) begin
            @(negedge w_CLK);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s:scoreboard got empty queue required an entry", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, ":phase"}, 64'(phases()), 64'(e.ph));
                chk({tag, ":addr"},  64'(b_MS_ADDR), 64'(e.addr));
                chk({tag, ":ci"},    64'(b_CI), 64'(e.ci));
                chk({tag, ":fst"},   64'(b_FST_OUT), 64'(e.fst));
                chk({tag, ":azero"}, 64'(w_A_ZERO), 64'(e.az));
                chk({tag, ":zero"},  64'(b_MS_ZERO), 64'(e.zero));
                chk({tag, ":din"},   64'(b_MS_DATA_IN), 64'(e.din));
            end
        end
    endtask

    task automatic do_reset(input string tag);
        w_RST_N = 1'b0;
        w_RUN   = 1'b0;
        w_A_NEG = 1'b0;
        a_val   = '0;
        sb.delete();
        for (int i = 0; i < 1024; i++) mem[i] = nopw;
        @(negedge w_CLK);
        chk({tag, ":rst_phase"}, 64'(phases()), 64'h0);
        chk({tag, ":rst_fst"},   64'(b_FST_OUT), 64'(OP_JMP));
        chk({tag, ":rst_ci"},    64'(b_CI), 64'h0);
        chk({tag, ":rst_addr"},  64'(b_MS_ADDR), 64'h0);
        w_RST_N = 1'b1;
    endtask

    initial begin
        nopw = mk(OP_NOP, 10'd0);
        beat_ph = '{4'b1010, 4'b0110, 4'b1001, 4'b0101, 4'b1010, 4'b0110, 4'b1001, 4'b0101};
        vt[0] = '{"sta", OP_STA, 10'd7, 10'd0, 1'b0, 40'h00000000AB, 40'h0, 1'b0, {40{1'b1}}, 40'h00000000AB, 10'd1};
        vt[1] = '{"lda", OP_LDA, 10'd3, 10'd0, 1'b0, 40'h0, 40'h0, 1'b1, 40'h0, 40'h0, 10'd1};
        vt[2] = '{"jmp", OP_JMP, 10'd9, 10'd3, 1'b0, 40'h0, 40'(mk(6'd0, 10'd20)), 1'b0, 40'h0, 40'h0, 10'd20};
        vt[3] = '{"cmp_neg", OP_CMP, 10'd30, 10'd4, 1'b1, 40'h0, 40'h0, 1'b0, 40'h0, 40'h0, 10'd6};
        vt[4] = '{"cmp_pos", OP_CMP, 10'd30, 10'd4, 1'b0, 40'h0, 40'h0, 1'b0, 40'h0, 40'h0, 10'd5};
        vt[5] = '{"unknown", OP_UNK, 10'd12, 10'd2, 1'b1, 40'h0, 40'h0, 1'b0, 40'h0, 40'h0, 10'd3};

`ifndef STEP_MODE_EN
        foreach (vt[k]) begin
            do_reset(vt[k].nm);
            mem[vt[k].opnd]  = vt[k].tgt == 40'h0 ? nopw : vt[k].tgt;
            mem[vt[k].start] = mk(vt[k].op, vt[k].opnd);
            w_A_NEG = vt[k].neg;
            a_val   = vt[k].aval;
            @(negedge w_CLK);
            w_RUN = 1'b1;
            for (int i = 0; i < int'(vt[k].start); i++) push_instr(10'(i), OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
            push_instr(vt[k].start, vt[k].op, vt[k].opnd, vt[k].az, vt[k].zero, vt[k].din);
            push_instr(vt[k].nxt, OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
            drain(vt[k].nm, 8 * (int'(vt[k].start) + 1) + 2);
            w_RUN = 1'b0;
            drain(vt[k].nm, 6);
            @(negedge w_CLK);
            chk({vt[k].nm, ":idle_phase"}, 64'(phases()), 64'h0);
        end

        do_reset("hlt");
        mem[2] = mk(OP_HLT, 10'd0);
        @(negedge w_CLK);
        w_RUN = 1'b1;
        push_instr(10'd0, OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
        push_instr(10'd1, OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
        push_instr(10'd2, OP_HLT, 10'd0, 1'b0, 40'h0, 40'h0);
        drain("hlt", 24);
        repeat (20) begin
            @(negedge w_CLK);
            chk("hlt:halted_phase", 64'(phases()), 64'h01);
        end
        w_RUN = 1'b0;
        @(negedge w_CLK);
        chk("hlt:released", 64'(phases()), 64'h0);
        @(negedge w_CLK);
        chk("hlt:idle", 64'(phases()), 64'h0);

        do_reset("wrap");
        mem[0]    = mk(OP_JMP, 10'd5);
        mem[5]    = mk(6'd0, 10'd1023);
        mem[1023] = nopw;
        @(negedge w_CLK);
        w_RUN = 1'b1;
        push_instr(10'd0, OP_JMP, 10'd5, 1'b0, 40'h0, 40'h0);
        push_instr(10'd1023, OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
        push_instr(10'd0, OP_JMP, 10'd5, 1'b0, 40'h0, 40'h0);
        drain("wrap", 18);
        w_RUN = 1'b0;
        drain("wrap", 6);
        @(negedge w_CLK);
        chk("wrap:idle", 64'(phases()), 64'h0);
`else
        do_reset("step");
        @(negedge w_CLK);
        w_RUN = 1'b1;
        push_instr(10'd0, OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
        drain("step", 8);
        repeat (3) begin
            @(negedge w_CLK);
            chk("step:pause_phase", 64'(phases()), 64'h0);
            chk("step:pause_ci", 64'(b_CI), 64'd1);
        end
        w_STEP = 1'b1;
        push_instr(10'd1, OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
        drain("step", 8);
        @(negedge w_CLK);
        chk("step:held_high_pause", 64'(phases()), 64'h0);
        w_RUN  = 1'b0;
        w_STEP = 1'b0;
        @(negedge w_CLK);
        chk("step:idle", 64'(phases()), 64'h0);
`endif

        do_reset("arst");
        @(negedge w_CLK);
        w_RUN = 1'b1;
        push_instr(10'd0, OP_NOP, 10'd0, 1'b0, 40'h0, 40'h0);
        drain("arst", 7);
        #2;
        w_RST_N = 1'b0;
        #1;
        chk("arst:phase", 64'(phases()), 64'h0);
        chk("arst:ci", 64'(b_CI), 64'h0);
        chk("arst:addr", 64'(b_MS_ADDR), 64'h0);
        chk("arst:fst", 64'(b_FST_OUT), 64'(OP_JMP));
        chk("arst:azero", 64'(w_A_ZERO), 64'h0);
        sb.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
